// File: rtl/reaction_game_ctrl.sv
// reaction_game_ctrl: reaction-timer game sequencer.
// IDLE -> WAIT (random pre-delay) -> RUN (GO lamp, BCD ms timer) -> CMP (best-time update).
// The optional early-press foul detection is compiled in when CHEAT_DETECT_EN is defined;
// without it a press during the pre-delay is ignored and foul stays 0.
module reaction_game_ctrl #(
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned MIN_WAIT_MS = 1000,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    output logic       go_led,
    output logic       busy,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] hs0,
    output logic [3:0] hs1,
    output logic [3:0] hs2,
    output logic [3:0] hs3,
    output logic       hs_valid,
    output logic       new_best,
    output logic       timeout,
    output logic       foul
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_CMP  = 2'd3;

    localparam int unsigned     PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [15:0]     MIN_WAIT  = 16'(MIN_WAIT_MS);

    logic [1:0]    state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [15:0]   wait_ctr_reg, wait_ctr_next;
    logic [15:0]   lfsr_reg, lfsr_next;
    logic [3:0]    digit_reg [4];
    logic [3:0]    digit_next [4];
    logic [3:0]    hs_reg [4];
    logic [3:0]    hs_next [4];
    logic          hs_valid_reg, hs_valid_next;
    logic          new_best_reg, new_best_next;
    logic          timeout_reg, timeout_next;
    logic          go_led_reg, go_led_next;
    logic          busy_reg, busy_next;
`ifdef CHEAT_DETECT_EN
    logic          foul_reg, foul_next;
`endif

    logic          tick;
    logic [3:0]    inc_digit [4];
    logic [3:0]    carry;
    logic [3:0]    inc_nine;
    logic          reach_max;
    logic [15:0]   cur_time;
    logic [15:0]   best_time;

    // ms tick: last count of the prescaler while the round clock is running
    assign tick = ((state_reg == ST_WAIT) || (state_reg == ST_RUN)) && (presc_reg == PRESC_MAX);

    // BCD increment of the current time; digit gi rolls over only when all lower digits are 9
    assign carry[0] = 1'b1;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
            assign inc_digit[gi] = carry[gi] ? ((digit_reg[gi] == 4'd9) ? 4'd0 : digit_reg[gi] + 4'd1)
                                             : digit_reg[gi];
            assign inc_nine[gi]  = (inc_digit[gi] == 4'd9);
            if (gi < 3) begin : g_carry
                assign carry[gi+1] = carry[gi] && (digit_reg[gi] == 4'd9);
            end
        end
    endgenerate

    // incremented value is 9999: saturate and end the round as a timeout
    assign reach_max = &inc_nine;

    // packed BCD compares lexicographically digit3..digit0 as a plain unsigned compare
    assign cur_time  = {digit_reg[3], digit_reg[2], digit_reg[1], digit_reg[0]};
    assign best_time = {hs_reg[3], hs_reg[2], hs_reg[1], hs_reg[0]};

    // Fibonacci LFSR, taps 16,14,13,11, free-running every clock
    assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

    // round sequencing, timer and best-time update
    always_comb begin
        state_next    = state_reg;
        wait_ctr_next = wait_ctr_reg;
        digit_next    = digit_reg;
        hs_next       = hs_reg;
        hs_valid_next = hs_valid_reg;
        new_best_next = new_best_reg;
        timeout_next  = timeout_reg;
`ifdef CHEAT_DETECT_EN
        foul_next     = foul_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_WAIT;
                    wait_ctr_next = MIN_WAIT + {6'd0, lfsr_reg[9:0]};
                    digit_next    = '{default: 4'd0};
                    new_best_next = 1'b0;
                    timeout_next  = 1'b0;
`ifdef CHEAT_DETECT_EN
                    foul_next     = 1'b0;
`endif
                end
            end
            ST_WAIT: begin
`ifdef CHEAT_DETECT_EN
                if (stop) begin
                    // early press: round ends as a foul, shown as 9999
                    state_next = ST_IDLE;
                    foul_next  = 1'b1;
                    digit_next = '{default: 4'd9};
                end else
`endif
                if (tick) begin
                    if (wait_ctr_reg <= 16'd1) begin
                        state_next = ST_RUN;
                    end else begin
                        wait_ctr_next = wait_ctr_reg - 16'd1;
                    end
                end
            end
            ST_RUN: begin
                // a press on a tick cycle wins; the count freezes without incrementing
                if (stop) begin
                    state_next = ST_CMP;
                end else if (tick) begin
                    digit_next = inc_digit;
                    if (reach_max) begin
                        timeout_next = 1'b1;
                        state_next   = ST_CMP;
                    end
                end
            end
            default: begin
                if (!timeout_reg && (!hs_valid_reg || (cur_time < best_time))) begin
                    hs_next       = digit_reg;
                    hs_valid_next = 1'b1;
                    new_best_next = 1'b1;
                end
                state_next = ST_IDLE;
            end
        endcase
    end

    // prescaler runs only in WAIT/RUN and restarts on every state change
    always_comb begin
        presc_next = '0;
        if ((state_next == state_reg) && ((state_reg == ST_WAIT) || (state_reg == ST_RUN))) begin
            presc_next = tick ? '0 : presc_reg + PW'(1);
        end
    end

    // status lamps are registered from the next state so they track it with no input paths
    always_comb begin
        go_led_next = (state_next == ST_RUN);
        busy_next   = (state_next != ST_IDLE);
    end

    // state registers; reset aborts any round and loses the best time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            presc_reg    <= '0;
            wait_ctr_reg <= '0;
            lfsr_reg     <= LFSR_SEED;
            digit_reg    <= '{default: 4'd0};
            hs_reg       <= '{default: 4'd0};
            hs_valid_reg <= 1'b0;
            new_best_reg <= 1'b0;
            timeout_reg  <= 1'b0;
            go_led_reg   <= 1'b0;
            busy_reg     <= 1'b0;
`ifdef CHEAT_DETECT_EN
            foul_reg     <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            presc_reg    <= presc_next;
            wait_ctr_reg <= wait_ctr_next;
            lfsr_reg     <= lfsr_next;
            digit_reg    <= digit_next;
            hs_reg       <= hs_next;
            hs_valid_reg <= hs_valid_next;
            new_best_reg <= new_best_next;
            timeout_reg  <= timeout_next;
            go_led_reg   <= go_led_next;
            busy_reg     <= busy_next;
`ifdef CHEAT_DETECT_EN
            foul_reg     <= foul_next;
`endif
        end
    end

    assign go_led   = go_led_reg;
    assign busy     = busy_reg;
    assign digit0   = digit_reg[0];
    assign digit1   = digit_reg[1];
    assign digit2   = digit_reg[2];
    assign digit3   = digit_reg[3];
    assign hs0      = hs_reg[0];
    assign hs1      = hs_reg[1];
    assign hs2      = hs_reg[2];
    assign hs3      = hs_reg[3];
    assign hs_valid = hs_valid_reg;
    assign new_best = new_best_reg;
    assign timeout  = timeout_reg;
`ifdef CHEAT_DETECT_EN
    assign foul     = foul_reg;
`else
    assign foul     = 1'b0;
`endif

endmodule
